branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 4: BTB index width; entries = 2**IDX_W, tag width = 30-IDX_W.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port fetch_pc  input  32  PC of the instruction being fetched this cycle.
REQ-005 SHALL have port br_taken  output  1  prediction for fetch_pc (1 = taken).
REQ-006 SHALL have port pred_target  output  32  next-PC prediction for fetch_pc.
REQ-007 SHALL have port br  input  1  branch-resolved strobe, already qualified by ihit; one pulse per resolved beq/bne.
REQ-008 SHALL have port br_result  input  1  actual outcome of the resolved branch (1 = taken); valid only when br=1.
REQ-009 SHALL have port br_pred  input  1  prediction originally issued for the resolved branch; valid only when br=1.
REQ-010 SHALL have port br_pc  input  32  PC of the resolved branch; valid only when br=1.
REQ-011 SHALL have port br_target  input  32  computed taken-target of the resolved branch; valid only when br=1.
REQ-012 SHALL have port br_count  output  32  number of resolved branches since reset.
REQ-013 SHALL have port mispred_count  output  32  number of mispredicted branches since reset.

Function
REQ-014 SHALL hold a direct-mapped BTB; each entry: valid, tag = pc[31:IDX_W+2], target[31:0], 2-bit counter ctr; index = pc[IDX_W+1:2].
REQ-015 Lookup SHALL be combinational from registered BTB state: hit = valid && tag matches fetch_pc.
REQ-016 br_taken SHALL be hit && ctr[1]; pred_target SHALL be entry target when br_taken=1, else fetch_pc+4 (mod 2**32).
REQ-017 When br=0, BTB and statistics SHALL be unchanged.
REQ-018 When br=1 and br_pc hits and br_result=1: ctr SHALL increment, saturating at 2'b11; target SHALL be overwritten with br_target.
REQ-019 When br=1 and br_pc hits and br_result=0: ctr SHALL decrement, saturating at 2'b00; target and valid unchanged.
REQ-020 When br=1 and br_pc misses and br_result=1: the entry SHALL be allocated (replacing any occupant): valid=1, tag from br_pc, target=br_target, ctr=2'b10.
REQ-021 When br=1 and br_pc misses and br_result=0: no allocation; the indexed entry SHALL be unchanged.
REQ-022 Counter state machine: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; taken moves up one state, not-taken down one, ends saturate.
REQ-023 Simultaneous update and lookup to the same index SHALL be read-before-write: the prediction in that cycle uses pre-update contents; the update is visible the following cycle.
REQ-024 When br=1, br_count SHALL increment by 1, saturating at 32'hFFFFFFFF.
REQ-025 When br=1 and br_result != br_pred, mispred_count SHALL increment by 1, saturating at 32'hFFFFFFFF.
REQ-026 fetch_pc[1:0] and br_pc[1:0] SHALL be ignored for indexing and tag compare.
REQ-027 Update latency SHALL be exactly one cycle: state written at the rising edge where br=1 is sampled.

Reset
REQ-028 While nRST=0, all valid bits, targets, tags and ctr SHALL be 0, and br_count and mispred_count SHALL be 0.
REQ-029 Immediately after reset, br_taken SHALL be 0 and pred_target SHALL be fetch_pc+4 for every fetch_pc.
REQ-030 Reset asserted mid-update SHALL win; no partial update SHALL survive deassertion.

Verification
REQ-031 Cold start: reset, fetch_pc=0x00000040 -> br_taken=0, pred_target=0x00000044, both counts 0.
REQ-032 Allocate: br=1, br_pc=0x40, br_result=1, br_pred=0, br_target=0x100; next cycle fetch_pc=0x40 -> br_taken=1, pred_target=0x100, br_count=1, mispred_count=1.
REQ-033 Saturation/hysteresis: from REQ-032 state, three taken then one not-taken on 0x40 -> ctr 11 then 10, still br_taken=1; a second not-taken -> ctr 01, br_taken=0, pred_target=0x44.
REQ-034 Aliasing: after REQ-032, taken update br_pc=0x80 (same index for IDX_W=4), br_target=0x200 -> fetch 0x40 gives br_taken=0, pred_target=0x44; fetch 0x80 gives pred_target=0x200.
REQ-035 Same-cycle collision: fetch_pc=0x40 with br=1 updating 0x40 to not-taken from ctr=10 -> that cycle br_taken=1; next cycle br_taken=0.
REQ-036 Not-taken miss and reset: br=1, br_pc=0x60, br_result=0 -> no entry, fetch 0x60 predicts 0x64; then assert nRST low mid-cycle -> counts and BTB immediately 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters for beq/bne prediction,
// plus saturating counts of resolved and mispredicted branches.
module branch_predictor #(
  parameter int IDX_W = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] fetch_pc,
  output logic        br_taken,
  output logic [31:0] pred_target,
  input  logic        br,
  input  logic        br_result,
  input  logic        br_pred,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_target,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    ctr_t             ctr;
  } btb_entry_t;

  btb_entry_t btb [ENTRIES];

  function automatic ctr_t ctr_up(input ctr_t c);
    return (c == STRONG_T) ? STRONG_T : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t ctr_dn(input ctr_t c);
    return (c == STRONG_NT) ? STRONG_NT : ctr_t'(c - 2'd1);
  endfunction

  // Lookup reads the registered array, so a same-cycle update is seen next cycle.
  logic [IDX_W-1:0] f_idx;
  btb_entry_t       f_entry;
  logic             f_hit;

  assign f_idx       = fetch_pc[IDX_W+1:2];
  assign f_entry     = btb[f_idx];
  assign f_hit       = f_entry.valid && (f_entry.tag == fetch_pc[31:IDX_W+2]);
  assign br_taken    = f_hit && f_entry.ctr[1];
  assign pred_target = br_taken ? f_entry.target : fetch_pc + 32'd4;

  logic [IDX_W-1:0] u_idx;
  btb_entry_t       u_entry;
  logic             u_hit;
  logic             upd_we;
  btb_entry_t       upd_entry;

  assign u_idx   = br_pc[IDX_W+1:2];
  assign u_entry = btb[u_idx];
  assign u_hit   = u_entry.valid && (u_entry.tag == br_pc[31:IDX_W+2]);

  // Word-aligned PCs: the byte-offset bits never take part in lookup.
  logic unused_br_pc_lsbs;
  assign unused_br_pc_lsbs = ^br_pc[1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    upd_we    = 1'b0;
    upd_entry = u_entry;
    if (br) begin
      if (u_hit) begin
        upd_we = 1'b1;
        if (br_result) begin
          upd_entry.ctr    = ctr_up(u_entry.ctr);
          upd_entry.target = br_target;
        end else begin
          upd_entry.ctr = ctr_dn(u_entry.ctr);
        end
      end else if (br_result) begin
        upd_we           = 1'b1;
        upd_entry.valid  = 1'b1;
        upd_entry.tag    = br_pc[31:IDX_W+2];
        upd_entry.target = br_target;
        upd_entry.ctr    = WEAK_T;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: the BTB array is reset explicitly; a cold predictor must never hit on stale tags.
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i] <= '0;
      end
    end else if (upd_we) begin
      // NOTE: non-blocking assignment keeps the lookup above on pre-update contents.
      btb[u_idx] <= upd_entry;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (br) begin
      if (br_count != '1) br_count <= br_count + 32'd1;
      if ((br_result != br_pred) && (mispred_count != '1))
        mispred_count <= mispred_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: the driver queues expected
// outputs per checked cycle, a monitor pops and compares them on the falling edge.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] fetch_pc;
  logic        br_taken;
  logic [31:0] pred_target;
  logic        br;
  logic        br_result;
  logic        br_pred;
  logic [31:0] br_pc;
  logic [31:0] br_target;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  branch_predictor #(.IDX_W(4)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .fetch_pc     (fetch_pc),
    .br_taken     (br_taken),
    .pred_target  (pred_target),
    .br           (br),
    .br_result    (br_result),
    .br_pred      (br_pred),
    .br_pc        (br_pc),
    .br_target    (br_target),
    .br_count     (br_count),
    .mispred_count(mispred_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        taken;
    logic [31:0] target;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, away from the rising edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".br_taken"}, {31'd0, br_taken}, {31'd0, e.taken});
        check({e.name, ".pred_target"}, pred_target, e.target);
        check({e.name, ".br_count"}, br_count, e.bc);
        check({e.name, ".mispred_count"}, mispred_count, e.mc);
      end
    end
  end

  // One cycle of stimulus; the update (if br=1) lands on the next rising edge.
  task automatic cycle(input string name, input logic [31:0] fpc,
                       input logic b, input logic res, input logic pred,
                       input logic [31:0] bpc, input logic [31:0] btgt,
                       input logic do_chk, input logic e_taken,
                       input logic [31:0] e_target, input logic [31:0] e_bc,
                       input logic [31:0] e_mc);
    exp_t e;
    @(posedge CLK);
    #1;
    fetch_pc  = fpc;
    br        = b;
    br_result = res;
    br_pred   = pred;
    br_pc     = bpc;
    br_target = btgt;
    if (do_chk) begin
      e.name = name; e.taken = e_taken; e.target = e_target; e.bc = e_bc; e.mc = e_mc;
      exp_q.push_back(e);
    end
    chk_en = do_chk;
  endtask

  task automatic look(input string name, input logic [31:0] fpc, input logic e_taken,
                      input logic [31:0] e_target, input logic [31:0] e_bc,
                      input logic [31:0] e_mc);
    cycle(name, fpc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, e_taken, e_target, e_bc, e_mc);
  endtask

  task automatic upd(input string name, input logic [31:0] fpc, input logic res,
                     input logic pred, input logic [31:0] bpc, input logic [31:0] btgt,
                     input logic e_taken, input logic [31:0] e_target,
                     input logic [31:0] e_bc, input logic [31:0] e_mc);
    cycle(name, fpc, 1'b1, res, pred, bpc, btgt, 1'b1, e_taken, e_target, e_bc, e_mc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0; fetch_pc = 32'h40; br = 1'b0; br_result = 1'b0;
    br_pred = 1'b0; br_pc = 32'h0; br_target = 32'h0;

    // Held in reset: everything reads cold even with br asserted.
    upd ("in_reset", 32'h40, 1'b1, 1'b0, 32'h40, 32'h100, 1'b0, 32'h44, 32'd0, 32'd0);
    @(negedge CLK); br = 1'b0; nRST = 1'b1;

    look("cold_40",   32'h40,       1'b0, 32'h44, 32'd0, 32'd0);
    look("cold_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0,  32'd0, 32'd0);

    // Allocate 0x40 -> 0x100, ctr=10 (mispredicted).
    upd ("alloc",     32'h40, 1'b1, 1'b0, 32'h40, 32'h100, 1'b0, 32'h44, 32'd0, 32'd1 - 32'd1);
    look("alloc_hit", 32'h40, 1'b1, 32'h100, 32'd1, 32'd1);

    // Three taken: 10 -> 11 -> 11 -> 11, then not-taken -> 10 still taken.
    upd ("t1",  32'h40, 1'b1, 1'b1, 32'h40, 32'h100, 1'b1, 32'h100, 32'd1, 32'd1);
    upd ("t2",  32'h40, 1'b1, 1'b1, 32'h40, 32'h100, 1'b1, 32'h100, 32'd2, 32'd1);
    upd ("t3",  32'h40, 1'b1, 1'b1, 32'h40, 32'h100, 1'b1, 32'h100, 32'd3, 32'd1);
    upd ("nt1", 32'h40, 1'b0, 1'b1, 32'h40, 32'h100, 1'b1, 32'h100, 32'd4, 32'd1);
    look("hyst", 32'h40, 1'b1, 32'h100, 32'd5, 32'd2);

    // Same-cycle collision: ctr 10 -> 01; this cycle still predicts taken.
    upd ("collide",      32'h40, 1'b0, 1'b1, 32'h40, 32'h100, 1'b1, 32'h100, 32'd5, 32'd2);
    look("collide_next", 32'h40, 1'b0, 32'h44, 32'd6, 32'd3);

    // Taken on hit overwrites the target: ctr 01 -> 10, target 0x140.
    upd ("retarget",     32'h40, 1'b1, 1'b0, 32'h40, 32'h140, 1'b0, 32'h44, 32'd6, 32'd3);
    look("retarget_hit", 32'h40, 1'b1, 32'h140, 32'd7, 32'd4);

    // Down to 00 and saturate there; one taken then reaches only 01.
    upd ("d1", 32'h40, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h140, 32'd7,  32'd4);
    upd ("d2", 32'h40, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h44,  32'd8,  32'd4);
    upd ("d3", 32'h40, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h44,  32'd9,  32'd4);
    upd ("u1", 32'h40, 1'b1, 1'b0, 32'h40, 32'h140, 1'b0, 32'h44, 32'd10, 32'd4);
    look("sat_low", 32'h40, 1'b0, 32'h44, 32'd11, 32'd5);

    // Aliasing: 0x80 shares index 0 and evicts 0x40.
    upd ("alias",     32'h80, 1'b1, 1'b0, 32'h80, 32'h200, 1'b0, 32'h84, 32'd11, 32'd5);
    look("alias_40",  32'h40, 1'b0, 32'h44,  32'd12, 32'd6);
    look("alias_80",  32'h80, 1'b1, 32'h200, 32'd12, 32'd6);
    look("alias_lsb", 32'h83, 1'b1, 32'h200, 32'd12, 32'd6);

    // Not-taken misses allocate nothing and leave the indexed entry alone.
    upd ("nt_miss60", 32'h60, 1'b0, 1'b1, 32'h60, 32'h300, 1'b0, 32'h64, 32'd12, 32'd6);
    look("miss60",    32'h60, 1'b0, 32'h64, 32'd13, 32'd7);
    upd ("nt_miss40", 32'h80, 1'b0, 1'b0, 32'h40, 32'h300, 1'b1, 32'h200, 32'd13, 32'd7);
    look("keep80",    32'h80, 1'b1, 32'h200, 32'd14, 32'd7);

    // Reset mid-cycle while a taken update is pending: reset wins at once.
    cycle("pre_rst", 32'h80, 1'b1, 1'b1, 1'b0, 32'h60, 32'h300, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0);
    #2 nRST = 1'b0;
    #1;
    n_checks++;
    if ({br_taken, pred_target, br_count, mispred_count} !== {1'b0, 32'h84, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL mid_rst: got taken=%0b tgt=0x%08h bc=%0d mc=%0d expected 0 0x00000084 0 0",
               br_taken, pred_target, br_count, mispred_count);
    end
    @(negedge CLK); br = 1'b0; nRST = 1'b1;
    look("post_rst_80", 32'h80, 1'b0, 32'h84, 32'd0, 32'd0);
    look("post_rst_60", 32'h60, 1'b0, 32'h64, 32'd0, 32'd0);

    @(posedge CLK); #1 chk_en = 1'b0;
    @(negedge CLK);
    check("sb_drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
